// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: glyphs (active-low,
// bit 6 = segment a) and the segment bit positions.
package seven_seg_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0001100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment glyph; purely combinational.
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'ha: seg = GLYPH_A;
      4'hb: seg = GLYPH_B;
      4'hc: seg = GLYPH_C;
      4'hd: seg = GLYPH_D;
      4'he: seg = GLYPH_E;
      4'hf: seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment display driver with per-slot anti-ghosting guard,
// shadowed display data, forced/leading-zero blanking and fully registered outputs.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gen_bad_digits
    $error("seven_seg_mux: NUM_DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < GUARD_CYCLES + 2) begin : gen_bad_div
    $error("seven_seg_mux: REFRESH_DIV must be >= GUARD_CYCLES+2");
  end

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap_div, wrap_idx;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;

  logic [3:0]              nibble;
  logic [6:0]              glyph;
  logic                    dp_sel, bm_sel, lz_sel, all_zero, dark, blank;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d, frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  always_comb begin
    wrap_div = (div_q == DIV_W'(REFRESH_DIV - 1));
    wrap_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));
    div_d    = wrap_div ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (wrap_div) begin
      idx_d = wrap_idx ? '0 : idx_q + 1'b1;
    end
  end

  // Outputs are computed for the upcoming counter state but from the current shadow,
  // so counters and outputs stay aligned while loads land one cycle later.
  always_comb begin
    nibble   = '0;
    dp_sel   = 1'b0;
    bm_sel   = 1'b0;
    lz_sel   = 1'b0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (value_q[4*i +: 4] == 4'h0);
      if (idx_d == IDX_W'(i)) begin
        nibble = value_q[4*i +: 4];
        dp_sel = dp_q[i];
        bm_sel = blank_q[i];
        lz_sel = all_zero && (i != 0);
      end
    end
  end

  seg_decode u_seg_decode (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    blank   = bm_sel | (lz_blank & lz_sel);
    dark    = !enable || (div_d < DIV_W'(GUARD_CYCLES));
    seg_d   = (dark || blank) ? SEG_BLANK : glyph;
    dp_n_d  = dark | ~dp_sel;
    frame_d = wrap_div & wrap_idx;
    an_d    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = dark || (idx_d != IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_q   <= SEG_BLANK;
      dp_n_q  <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      if (load) begin
        value_q <= value;
        dp_q    <= dp;
        blank_q <= blank_mask;
      end
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: directed steps then random traffic, every cycle compared
// against a time-indexed behavioural model of the display.
module tb_seven_seg_mux;

  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 1;

  logic         clk;
  logic         rst;
  logic         load;
  logic [15:0]  value;
  logic [3:0]   dp;
  logic [3:0]   blank_mask;
  logic         lz_blank;
  logic         enable;
  logic [6:0]   seg;
  logic         dp_n;
  logic [3:0]   an;
  logic         frame;

  seven_seg_mux #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .blank_mask (blank_mask),
    .lz_blank   (lz_blank),
    .enable     (enable),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_ref [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int errors = 0;
  int checks = 0;

  // Model: t counts cycles since the cycle following the last reset edge.
  int          t = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_bm = '0;
  logic        cur_lz = 1'b0;
  logic        cur_en = 1'b1;

  logic [6:0]  e_seg;
  logic        e_dpn;
  logic [3:0]  e_an;
  logic        e_frame;

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    int div, dig;
    logic [15:0] upper;
    logic blk;
    rst = r; load = ld; value = v; dp = d; blank_mask = b;
    lz_blank = cur_lz; enable = cur_en;
    @(posedge clk);
    e_seg = 7'h7f; e_dpn = 1'b1; e_an = 4'hf; e_frame = 1'b0;
    if (r) begin
      t = 0; m_val = '0; m_dp = '0; m_bm = '0;
    end else begin
      t = t + 1;
      div = t % R;
      dig = (t / R) % N;
      e_frame = (t % (R * N)) == 0;
      if (cur_en && div >= G) begin
        upper = m_val >> (4 * dig);
        blk   = m_bm[dig] || (cur_lz && dig != 0 && upper == 16'h0);
        e_an  = ~(4'b0001 << dig);
        e_seg = blk ? 7'h7f : glyph_ref[upper[3:0]];
        e_dpn = ~m_dp[dig];
      end
      if (ld) begin
        m_val = v; m_dp = d; m_bm = b;
      end
    end
    #1;
    checks++;
    assert (an === e_an) else begin
      errors++; $error("FAIL an t=%0d got %b want %b", t, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++; $error("FAIL seg t=%0d got %b want %b", t, seg, e_seg);
    end
    checks++;
    assert (dp_n === e_dpn) else begin
      errors++; $error("FAIL dp_n t=%0d got %b want %b", t, dp_n, e_dpn);
    end
    checks++;
    assert (frame === e_frame) else begin
      errors++; $error("FAIL frame t=%0d got %b want %b", t, frame, e_frame);
    end
  endtask

  // Idle cycles drive junk on the data inputs to show they are ignored without load.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    step(1'b0, 1'b1, v, d, b);
  endtask

  initial begin
    clk = 1'b0;
    repeat (3) step(1'b1, 1'b1, 16'hffff, 4'hf, 4'h0);
    ld(16'h12af, 4'b0100, 4'h0);
    idle(40);

    cur_lz = 1'b1;
    ld(16'h0030, 4'h0, 4'h0);
    idle(20);
    ld(16'h0000, 4'h0, 4'h0);
    idle(20);
    ld(16'h0500, 4'b0010, 4'b0000);
    idle(18);
    cur_lz = 1'b0;

    idle(16 - (t % 16) + 1);
    ld(16'h0008, 4'h0, 4'h0);
    idle(18);

    ld(16'h1111, 4'h0, 4'h0);
    ld(16'h4e6c, 4'b1001, 4'b0010);
    idle(20);

    cur_en = 1'b0;
    idle(20);
    cur_en = 1'b1;
    idle(7);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(20);

    for (int k = 0; k < 600; k++) begin
      logic [15:0] v;
      logic [3:0]  b;
      if (k % 60 == 0) cur_lz = ~cur_lz;
      cur_en = ($urandom_range(0, 15) != 0);
      v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), v, 4'($urandom), b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
